// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy blocks: position field widths, the dead-enemy
// position code and the row phase encodings.
package enemy_pkg;
   localparam int X_W   = 10;
   localparam int Y_W   = 9;
   localparam int POS_W = X_W + Y_W;

   localparam logic [POS_W-1:0] NONE_POS = {POS_W{1'b1}};

   typedef enum logic [1:0] {
      PH_IDLE       = 2'b00,
      PH_MOVE_RIGHT = 2'b01,
      PH_MOVE_LEFT  = 2'b10,
      PH_DESCEND    = 2'b11
   } phase_t;
endpackage

// File: rtl/enemy_row_mover_if.sv
// Control and status bundle between the game sequencer (master) and one enemy row (slave).
interface enemy_row_mover_if
   import enemy_pkg::*;
#(
   parameter int N_ENEMY = 8
);
   // No valid/ready pairs here: i_Start, i_Tick and i_Kill are single-cycle pulses
   // sampled on the rising edge, i_Freeze is a level, and every o_* is a registered status.
   logic                       i_Start;
   logic                       i_Tick;
   logic                       i_Freeze;
   logic [N_ENEMY-1:0]         i_Kill;
   logic [POS_W*N_ENEMY-1:0]   o_EnemyPosition;
   logic [1:0]                 o_PhaseState;
   logic                       o_RowCleared;
   logic                       o_Landed;

   modport master (
      output i_Start, i_Tick, i_Freeze, i_Kill,
      input  o_EnemyPosition, o_PhaseState, o_RowCleared, o_Landed
   );

   modport slave (
      input  i_Start, i_Tick, i_Freeze, i_Kill,
      output o_EnemyPosition, o_PhaseState, o_RowCleared, o_Landed
   );
endinterface

// File: rtl/enemy_row_bounds.sv
// Horizontal extent of the living part of a row: min and max x over the alive mask.
module enemy_row_bounds
   import enemy_pkg::*;
#(
   parameter int N_ENEMY = 8
) (
   input  logic [N_ENEMY-1:0]     i_Alive,
   input  logic [X_W*N_ENEMY-1:0] i_X,
   output logic [X_W-1:0]         o_MinX,
   output logic [X_W-1:0]         o_MaxX
);

   // With nothing alive the result is min=all ones, max=0; callers never step an empty row.
   always_comb begin
      o_MinX = {X_W{1'b1}};
      o_MaxX = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         if (i_Alive[i]) begin
            if (i_X[X_W*i +: X_W] < o_MinX) o_MinX = i_X[X_W*i +: X_W];
            if (i_X[X_W*i +: X_W] > o_MaxX) o_MaxX = i_X[X_W*i +: X_W];
         end
      end
   end

endmodule

// File: rtl/enemy_row_mover.sv
// One row of enemies marching right/left, descending at the walls, with per-enemy kills.
module enemy_row_mover
   import enemy_pkg::*;
#(
   parameter int               N_ENEMY           = 8,
   parameter logic [Y_W-1:0]   VERTICAL_POSITION = 9'd168,
   parameter logic [X_W-1:0]   X_START           = 10'd100,
   parameter logic [X_W-1:0]   SPACING           = 10'd40,
   parameter logic [X_W-1:0]   STEP              = 10'd8,
   parameter logic [X_W-1:0]   X_MIN             = 10'd16,
   parameter logic [X_W-1:0]   X_MAX             = 10'd600,
   parameter logic [Y_W-1:0]   DESCEND_STEP      = 9'd16,
   parameter logic [Y_W-1:0]   Y_MAX             = 9'd400,
   parameter int               TICK_DIV          = 4,
   parameter logic [POS_W-1:0] NONE              = NONE_POS
) (
   input logic              i_Clk,
   input logic              i_Rst,
   enemy_row_mover_if.slave bus
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [X_W*N_ENEMY-1:0]   r_x;
   logic [N_ENEMY-1:0]       r_alive;
   logic [Y_W-1:0]           r_y;
   logic [CNT_W-1:0]         r_cnt;
   phase_t                   r_state;
   logic                     r_ret_left;
   logic                     r_cleared;
   logic                     r_landed;
   logic [POS_W*N_ENEMY-1:0] r_pos;

   logic [X_W*N_ENEMY-1:0]   w_x_nxt;
   logic [N_ENEMY-1:0]       w_alive_nxt;
   logic [Y_W-1:0]           w_y_nxt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   phase_t                   w_state_nxt;
   logic                     w_ret_left_nxt;
   logic                     w_cleared_nxt;
   logic                     w_landed_nxt;
   logic [POS_W*N_ENEMY-1:0] w_pos_nxt;

   logic [N_ENEMY-1:0] w_alive_post;
   logic [X_W-1:0]     w_min_x;
   logic [X_W-1:0]     w_max_x;
   logic               w_tick_en;
   logic               w_step;
   logic               w_wipe;
   logic               w_right_hit;
   logic               w_left_hit;
   logic [Y_W:0]       w_y_sum;
   logic [Y_W-1:0]     w_y_desc;

   // Wall checks look at enemies surviving this cycle's kills, not the registered mask.
   assign w_alive_post = r_alive & ~bus.i_Kill;

   enemy_row_bounds #(.N_ENEMY(N_ENEMY)) u_bounds (
      .i_Alive (w_alive_post),
      .i_X     (r_x),
      .o_MinX  (w_min_x),
      .o_MaxX  (w_max_x)
   );

   assign w_tick_en   = bus.i_Tick && !bus.i_Freeze && (r_state != PH_IDLE);
   assign w_step      = w_tick_en && (r_cnt == CNT_LAST);
   assign w_wipe      = (r_alive != '0) && (w_alive_post == '0);
   assign w_right_hit = ({1'b0, w_max_x} + {1'b0, STEP}) > {1'b0, X_MAX};
   assign w_left_hit  = w_min_x < (X_MIN + STEP);
   assign w_y_sum     = {1'b0, r_y} + {1'b0, DESCEND_STEP};
   assign w_y_desc    = (w_y_sum > {1'b0, Y_MAX}) ? Y_MAX : w_y_sum[Y_W-1:0];

   // State register: all sequential state, including the registered outputs.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst) begin
         r_x        <= '0;
         r_alive    <= '0;
         r_y        <= VERTICAL_POSITION;
         r_cnt      <= '0;
         r_state    <= PH_IDLE;
         r_ret_left <= 1'b0;
         r_cleared  <= 1'b0;
         r_landed   <= 1'b0;
         r_pos      <= {N_ENEMY{NONE}};
      end else begin
         r_x        <= w_x_nxt;
         r_alive    <= w_alive_nxt;
         r_y        <= w_y_nxt;
         r_cnt      <= w_cnt_nxt;
         r_state    <= w_state_nxt;
         r_ret_left <= w_ret_left_nxt;
         r_cleared  <= w_cleared_nxt;
         r_landed   <= w_landed_nxt;
         r_pos      <= w_pos_nxt;
      end
   end

   // Next-state: start beats kills, kills beat the step; a wiping kill suppresses the step.
   always_comb begin
      w_x_nxt        = r_x;
      w_alive_nxt    = r_alive;
      w_y_nxt        = r_y;
      w_cnt_nxt      = r_cnt;
      w_state_nxt    = r_state;
      w_ret_left_nxt = r_ret_left;
      w_cleared_nxt  = r_cleared;
      if (bus.i_Start) begin
         w_alive_nxt    = '1;
         for (int i = 0; i < N_ENEMY; i++) begin
            w_x_nxt[X_W*i +: X_W] = X_START + X_W'(i) * SPACING;
         end
         w_y_nxt        = VERTICAL_POSITION;
         w_cnt_nxt      = '0;
         w_state_nxt    = PH_MOVE_RIGHT;
         w_ret_left_nxt = 1'b0;
         w_cleared_nxt  = 1'b0;
      end else if (w_wipe) begin
         w_alive_nxt   = '0;
         w_state_nxt   = PH_IDLE;
         w_cleared_nxt = 1'b1;
      end else begin
         w_alive_nxt = w_alive_post;
         if (w_tick_en) w_cnt_nxt = w_step ? '0 : r_cnt + 1'b1;
         if (w_step) begin
            // Dead enemies move too, so the formation stays rigid.
            case (r_state)
               PH_MOVE_RIGHT: begin
                  if (w_right_hit) begin
                     w_state_nxt    = PH_DESCEND;
                     w_ret_left_nxt = 1'b1;
                  end else begin
                     for (int i = 0; i < N_ENEMY; i++) w_x_nxt[X_W*i +: X_W] = r_x[X_W*i +: X_W] + STEP;
                  end
               end
               PH_MOVE_LEFT: begin
                  if (w_left_hit) begin
                     w_state_nxt    = PH_DESCEND;
                     w_ret_left_nxt = 1'b0;
                  end else begin
                     for (int i = 0; i < N_ENEMY; i++) w_x_nxt[X_W*i +: X_W] = r_x[X_W*i +: X_W] - STEP;
                  end
               end
               PH_DESCEND: begin
                  w_y_nxt     = w_y_desc;
                  w_state_nxt = r_ret_left ? PH_MOVE_LEFT : PH_MOVE_RIGHT;
               end
               default: ;
            endcase
         end
      end
   end

   // Output decode from next-state values so the registered outputs track state without lag.
   always_comb begin
      w_pos_nxt = '0;
      for (int i = 0; i < N_ENEMY; i++) begin
         w_pos_nxt[POS_W*i +: POS_W] = w_alive_nxt[i] ? {w_x_nxt[X_W*i +: X_W], w_y_nxt} : NONE;
      end
      w_landed_nxt = (w_y_nxt == Y_MAX) && (w_alive_nxt != '0);
   end

   assign bus.o_EnemyPosition = r_pos;
   assign bus.o_PhaseState    = r_state;
   assign bus.o_RowCleared    = r_cleared;
   assign bus.o_Landed        = r_landed;

endmodule

// File: tb/tb_enemy_row_mover.sv
// Directed bench for enemy_row_mover with four enemies and default geometry.
module tb_enemy_row_mover;

   localparam int N = 4;
   localparam int W = 19 * N;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [W-1:0] exp_q[$];

   enemy_row_mover_if #(.N_ENEMY(N)) bus ();

   enemy_row_mover #(.N_ENEMY(N)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         bus.i_Tick = 1'b1;
         cycle();
         bus.i_Tick = 1'b0;
      end
   endtask

   task automatic do_steps(input int n);
      tick_n(4 * n);
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      logic [W-1:0] e;
      exp_q.push_back(exp);
      e = exp_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   function automatic logic [W-1:0] exp_row(input logic [9:0] x0, input logic [8:0] y,
                                            input logic [N-1:0] alive);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         r[19*i +: 19] = alive[i] ? {x0 + 10'(40 * i), y} : 19'h7FFFF;
      end
      return r;
   endfunction

   initial begin
      int   budget;
      int   descents_at_max;
      logic [8:0] y_prev;
      logic [8:0] y_now;
      logic [8:0] y_before_max;
      logic       landed_before_max;
      logic [1:0] ph_prev;
      logic [W-1:0] all_none;
      all_none = '1;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus.i_Start  = 1'b0;
      bus.i_Tick   = 1'b0;
      bus.i_Freeze = 1'b0;
      bus.i_Kill   = '0;

      // Reset state
      cycle();
      cycle();
      check("rst_pos",     bus.o_EnemyPosition, all_none);
      check("rst_phase",   W'(bus.o_PhaseState), W'(2'b00));
      check("rst_cleared", W'(bus.o_RowCleared), W'(1'b0));
      check("rst_landed",  W'(bus.o_Landed), W'(1'b0));

      // Start a fresh formation
      rst = 1'b1;
      cycle();
      bus.i_Start = 1'b1;
      cycle();
      bus.i_Start = 1'b0;
      check("start_pos",   bus.o_EnemyPosition, exp_row(10'd100, 9'd168, 4'b1111));
      check("start_phase", W'(bus.o_PhaseState), W'(2'b01));

      // Tick divider: the fourth tick steps
      tick_n(3);
      check("tick3_pos", bus.o_EnemyPosition, exp_row(10'd100, 9'd168, 4'b1111));
      tick_n(1);
      check("tick4_pos", bus.o_EnemyPosition, exp_row(10'd108, 9'd168, 4'b1111));
      tick_n(4);
      check("tick8_pos", bus.o_EnemyPosition, exp_row(10'd116, 9'd168, 4'b1111));

      // Freeze holds counter and position
      bus.i_Freeze = 1'b1;
      tick_n(3);
      bus.i_Freeze = 1'b0;
      check("freeze_pos", bus.o_EnemyPosition, exp_row(10'd116, 9'd168, 4'b1111));

      // March right to the wall
      do_steps(45);
      check("right_596", bus.o_EnemyPosition, exp_row(10'd476, 9'd168, 4'b1111));
      do_steps(1);
      check("wall_pos",   bus.o_EnemyPosition, exp_row(10'd476, 9'd168, 4'b1111));
      check("wall_phase", W'(bus.o_PhaseState), W'(2'b11));
      do_steps(1);
      check("desc_pos",   bus.o_EnemyPosition, exp_row(10'd476, 9'd184, 4'b1111));
      check("desc_phase", W'(bus.o_PhaseState), W'(2'b10));
      do_steps(1);
      check("left_pos",   bus.o_EnemyPosition, exp_row(10'd468, 9'd184, 4'b1111));

      // Kill enemy 3 alone, then march left until enemy 0 sits inside the left margin
      bus.i_Kill = 4'b1000;
      cycle();
      bus.i_Kill = '0;
      check("kill3_pos", bus.o_EnemyPosition, exp_row(10'd468, 9'd184, 4'b0111));
      do_steps(56);
      check("left_20", bus.o_EnemyPosition, exp_row(10'd20, 9'd184, 4'b0111));

      // Kill enemy 0 on the step tick: bounds come from enemies 1-2, so the row keeps moving
      tick_n(3);
      bus.i_Kill = 4'b0001;
      tick_n(1);
      bus.i_Kill = '0;
      check("kill0_step_pos",   bus.o_EnemyPosition, exp_row(10'd12, 9'd184, 4'b0110));
      check("kill0_step_phase", W'(bus.o_PhaseState), W'(2'b10));

      // Kill everything on a step tick
      tick_n(3);
      bus.i_Kill = 4'b1111;
      tick_n(1);
      bus.i_Kill = '0;
      check("wipe_pos",     bus.o_EnemyPosition, all_none);
      check("wipe_phase",   W'(bus.o_PhaseState), W'(2'b00));
      check("wipe_cleared", W'(bus.o_RowCleared), W'(1'b1));
      check("wipe_landed",  W'(bus.o_Landed), W'(1'b0));
      tick_n(4);
      check("idle_hold_phase",   W'(bus.o_PhaseState), W'(2'b00));
      check("idle_hold_cleared", W'(bus.o_RowCleared), W'(1'b1));

      // Start together with kills: kills ignored
      bus.i_Start = 1'b1;
      bus.i_Kill  = 4'b1111;
      cycle();
      bus.i_Start = 1'b0;
      bus.i_Kill  = '0;
      check("restart_pos",     bus.o_EnemyPosition, exp_row(10'd100, 9'd168, 4'b1111));
      check("restart_cleared", W'(bus.o_RowCleared), W'(1'b0));
      check("restart_phase",   W'(bus.o_PhaseState), W'(2'b01));

      // Descend repeatedly until the row lands, then once more at the floor
      budget            = 3000;
      descents_at_max   = 0;
      y_prev            = 9'd168;
      y_before_max      = 9'd0;
      landed_before_max = 1'b1;
      ph_prev           = bus.o_PhaseState;
      while (budget > 0 && descents_at_max < 2) begin
         do_steps(1);
         budget--;
         y_now = bus.o_EnemyPosition[8:0];
         if (ph_prev == 2'b11 && bus.o_PhaseState != 2'b11 && y_now == 9'd400) descents_at_max++;
         if (y_now != y_prev && y_now == 9'd400) begin
            y_before_max = y_prev;
         end
         if (y_now != 9'd400) landed_before_max = bus.o_Landed;
         y_prev  = y_now;
         ph_prev = bus.o_PhaseState;
      end
      check("land_budget",       W'(descents_at_max), W'(2));
      check("land_y",            W'(bus.o_EnemyPosition[8:0]), W'(9'd400));
      check("land_prev_y",       W'(y_before_max), W'(9'd392));
      check("land_flag_before",  W'(landed_before_max), W'(1'b0));
      check("land_flag",         W'(bus.o_Landed), W'(1'b1));
      check("land_slot3_y",      W'(bus.o_EnemyPosition[19*3 +: 9]), W'(9'd400));

      // Mid-run reset discards the formation and stays idle
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      check("mrst_pos",     bus.o_EnemyPosition, all_none);
      check("mrst_phase",   W'(bus.o_PhaseState), W'(2'b00));
      check("mrst_cleared", W'(bus.o_RowCleared), W'(1'b0));
      check("mrst_landed",  W'(bus.o_Landed), W'(1'b0));
      tick_n(8);
      check("mrst_idle_phase", W'(bus.o_PhaseState), W'(2'b00));
      check("mrst_idle_pos",   bus.o_EnemyPosition, all_none);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/enemy_row_mover.md
ENEMY_ROW_MOVER -- requirements
Module: Enemy_Row_Mover

Interface
REQ-001 SHALL have parameter N_ENEMY, default 8, enemies per row.
REQ-002 SHALL have parameter VERTICAL_POSITION, default 9'd168, starting row y.
REQ-003 SHALL have parameters X_START 10'd100, SPACING 10'd40, STEP 10'd8, X_MIN 10'd16, X_MAX 10'd600, DESCEND_STEP 9'd16, Y_MAX 9'd400, TICK_DIV 4: formation geometry and speed.
REQ-004 SHALL have parameter NONE, default {19{1'b1}}, the position code for a dead enemy.
REQ-005 i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 i_Rst  input  1  reset, synchronous, active-low.
REQ-007 i_Start  input  1  one-cycle pulse; loads a fresh formation.
REQ-008 i_Tick  input  1  one-cycle frame pulse.
REQ-009 i_Freeze  input  1  level; while high, tick counting holds.
REQ-010 i_Kill  input  N_ENEMY  per-enemy hit pulses.
REQ-011 o_EnemyPosition  output  19*N_ENEMY  enemy i at [19*i +: 19] = {x[9:0], y[8:0]}, or NONE if dead.
REQ-012 o_PhaseState  output  2  00 IDLE, 01 MOVE_RIGHT, 10 MOVE_LEFT, 11 DESCEND.
REQ-013 o_RowCleared  output  1  high when no enemy alive after a start.
REQ-014 o_Landed  output  1  high when row y >= Y_MAX.

Function
REQ-015 SHALL hold per-enemy x (10 bit) and alive, one shared row y (9 bit), a tick counter (clog2(TICK_DIV) bits), a state, and a return-direction bit; all outputs registered.
REQ-016 On i_Start: alive all ones; x[i] = X_START + i*SPACING; y = VERTICAL_POSITION; counter 0; state MOVE_RIGHT; o_RowCleared 0. Visible the next cycle.
REQ-017 A step event SHALL occur when i_Tick=1, i_Freeze=0, state is not IDLE, and counter == TICK_DIV-1; counter then goes to 0, otherwise it increments on each unfrozen tick.
REQ-018 Bounds SHALL be the min/max x over post-kill alive enemies (alive & ~i_Kill) in the same cycle.
REQ-019 MOVE_RIGHT step: if max_x + STEP > X_MAX (11-bit compare), go to DESCEND with return-direction LEFT and leave x unchanged; otherwise every x += STEP.
REQ-020 MOVE_LEFT step: if min_x < X_MIN + STEP, go to DESCEND with return-direction RIGHT and leave x unchanged; otherwise every x -= STEP.
REQ-021 DESCEND step: y = min(y + DESCEND_STEP, Y_MAX), computed in 10 bits; state goes to the stored return direction.
REQ-022 x of dead enemies SHALL keep updating so revived geometry stays consistent; only the output is masked to NONE.
REQ-023 i_Kill[i] SHALL clear alive[i] on the next edge; kill of a dead enemy has no effect.
REQ-024 Kills that leave no alive enemy SHALL set state IDLE and o_RowCleared=1 next cycle, held until i_Start; no step occurs in that cycle.
REQ-025 o_Landed SHALL be asserted while y == Y_MAX and alive is nonzero; movement continues.
REQ-026 Priority SHALL be i_Start > i_Kill > step; i_Start with i_Kill in the same cycle ignores i_Kill.
REQ-027 i_Freeze SHALL hold the counter and position while kills are still accepted.

Reset
REQ-028 With i_Rst=0 at an edge: alive 0, x 0, y VERTICAL_POSITION, counter 0, state IDLE; o_EnemyPosition all NONE; o_PhaseState 00; o_RowCleared 0; o_Landed 0.
REQ-029 Reset mid-operation SHALL discard the formation; the block stays IDLE until i_Start.

Structure
REQ-030 enemy_pkg SHALL hold NONE, X/Y field widths, and the state encodings; these are shared with the other enemy blocks.
REQ-031 Sub-module Enemy_Row_Bounds SHALL compute min_x and max_x from the alive mask and x vector combinationally; the remainder stays in Enemy_Row_Mover.

Verification (N_ENEMY=4, defaults otherwise)
REQ-032 Reset, then i_Start -> x = 100/140/180/220, y=168, o_PhaseState=01, no NONE slots.
REQ-033 8 i_Tick pulses -> exactly 2 steps; x = 116/156/196/236; 3 ticks with i_Freeze=1 -> no change.
REQ-034 Run right until max_x=596 -> next step: DESCEND with x unchanged; next step: y=184, state 10; following step: x decreases by 8.
REQ-035 Kill enemy 3, then kill enemy 0 while a step fires -> slots 3 and 0 read NONE; bounds taken from enemies 1–2 in that step.
REQ-036 Kill all four in one cycle together with a step -> IDLE, o_RowCleared=1, no movement; i_Start -> fresh formation, o_RowCleared=0.
REQ-037 Force repeated descents to y=400 -> y saturates at 400, o_Landed=1; a mid-run i_Rst=0 -> all outputs return to reset values.
